// File: rtl/sha256_pkg.sv
// Shared widths, enums and helpers for the SHA-256 message unpadder.
package sha256_pkg;

  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_LEN_W   = 64;
  localparam int SHA256_CNT_W   = 55;

  typedef enum logic [1:0] {
    SCHEME_SHA256 = 2'b00,
    SCHEME_SHA224 = 2'b01,
    SCHEME_SHA512 = 2'b10,
    SCHEME_SHA384 = 2'b11
  } sha256_scheme_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_EMIT_HOLD = 3'd2,
    ST_EMIT_TAIL = 3'd3,
    ST_CFG_WAIT  = 3'd4
  } unpad_state_e;

  // Number of message bits carried by the final data block; a nonzero
  // length that is a multiple of 512 fills the whole block.
  function automatic logic [9:0] final_block_bits(input logic [SHA256_LEN_W-1:0] len);
    if (len[8:0] == 9'd0 && len != '0) return 10'd512;
    return {1'b0, len[8:0]};
  endfunction

endpackage

// File: rtl/sha256_unpad_mask.sv
// Keeps the top i_nbits bits of a 512-bit block and zeroes the rest.
module sha256_unpad_mask
  import sha256_pkg::*;
(
  input  logic [SHA256_BLOCK_W-1:0] i_data,
  input  logic [9:0]                i_nbits,
  output logic [SHA256_BLOCK_W-1:0] o_data
);

  logic [SHA256_BLOCK_W-1:0] w_keep;

  assign w_keep = ~({SHA256_BLOCK_W{1'b1}} >> i_nbits);
  assign o_data = i_data & w_keep;

endmodule

// File: rtl/sha256_message_unpad.sv
// Strips SHA-256 padding from a stream of 512-bit blocks and reports the message length.
// Optional padding checker: define SHA256_MESSAGE_UNPAD_CHECK_EN.
module sha256_message_unpad
  import sha256_pkg::*;
#(
  parameter logic [1:0] SCHEME_ID = 2'b00
) (
  input  logic                      clk,
  input  logic                      sync_rst,
  input  logic                      en,
  input  logic [SHA256_BLOCK_W-1:0] data_in,
  input  logic                      data_in_valid,
  input  logic                      data_in_last,
  output logic                      data_in_ready,
  output logic [SHA256_BLOCK_W-1:0] data_out,
  output logic                      data_out_valid,
  output logic                      data_out_last,
  input  logic                      data_out_ready,
  output logic [SHA256_LEN_W-1:0]   cfg_size,
  output logic [1:0]                cfg_scheme,
  output logic                      cfg_last,
  output logic                      cfg_valid,
  input  logic                      cfg_ready,
  output logic                      err
);

  unpad_state_e              r_state;
  logic [SHA256_BLOCK_W-1:0] r_hold;
  logic                      r_hold_vld;
  logic [SHA256_BLOCK_W-1:0] r_tail;
  logic [SHA256_LEN_W-1:0]   r_len;
  logic [SHA256_CNT_W-1:0]   r_nblk;
  logic [SHA256_CNT_W-1:0]   r_cnt;
  logic [SHA256_BLOCK_W-1:0] r_out;
  logic                      r_out_vld;
  logic                      r_out_last;
  logic                      r_cfg_vld;
  logic [SHA256_LEN_W-1:0]   r_cfg_size;

  logic                      w_slot_free;
  logic                      w_cfg_free;
  logic                      w_in_ready;
  logic                      w_accept;
  logic [SHA256_CNT_W-1:0]   w_cnt_inc;
  logic [SHA256_CNT_W:0]     w_dblk;
  logic                      w_d_eq_n;
  logic                      w_len_zero;
  logic [SHA256_BLOCK_W-1:0] w_mask_src;
  logic [SHA256_BLOCK_W-1:0] w_masked;

  assign w_slot_free = !r_out_vld || data_out_ready;
  assign w_cfg_free  = !r_cfg_vld || cfg_ready;
  assign w_in_ready  = en && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && w_slot_free));
  assign w_accept    = w_in_ready && data_in_valid;
  assign w_cnt_inc   = r_cnt + {{(SHA256_CNT_W-1){1'b0}}, 1'b1};

  // D = ceil(L/512); D == N means the tail block still carries message bits.
  assign w_dblk     = {1'b0, r_len[63:9]} + {{SHA256_CNT_W{1'b0}}, |r_len[8:0]};
  assign w_d_eq_n   = (w_dblk == {1'b0, r_nblk});
  assign w_len_zero = (r_len == '0);
  assign w_mask_src = (r_state == ST_EMIT_HOLD) ? r_hold : r_tail;

  sha256_unpad_mask u_mask (
    .i_data  (w_mask_src),
    .i_nbits (final_block_bits(r_len)),
    .o_data  (w_masked)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_tail     <= '0;
      r_len      <= '0;
      r_nblk     <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_cfg_vld  <= 1'b0;
      r_cfg_size <= '0;
    end else begin
      // Output handshakes drain even while en is low.
      if (data_out_ready) r_out_vld <= 1'b0;
      if (cfg_ready)      r_cfg_vld <= 1'b0;
      if (en) begin
        case (r_state)
          ST_IDLE, ST_HOLD: begin
            if (w_accept) begin
              r_cnt <= w_cnt_inc;
              if (!data_in_last) begin
                if (r_hold_vld) begin
                  r_out      <= r_hold;
                  r_out_last <= 1'b0;
                  r_out_vld  <= 1'b1;
                end
                r_hold     <= data_in;
                r_hold_vld <= 1'b1;
                r_state    <= ST_HOLD;
              end else begin
                r_tail     <= data_in;
                r_len      <= data_in[SHA256_LEN_W-1:0];
                r_nblk     <= w_cnt_inc;
                r_cfg_vld  <= 1'b1;
                r_cfg_size <= data_in[SHA256_LEN_W-1:0];
                r_state    <= r_hold_vld ? ST_EMIT_HOLD : ST_EMIT_TAIL;
              end
            end
          end
          ST_EMIT_HOLD: begin
            if (w_len_zero) begin
              r_hold_vld <= 1'b0;
              r_state    <= ST_CFG_WAIT;
            end else if (w_slot_free) begin
              r_hold_vld <= 1'b0;
              r_out_vld  <= 1'b1;
              if (w_d_eq_n) begin
                r_out      <= r_hold;
                r_out_last <= 1'b0;
                r_state    <= ST_EMIT_TAIL;
              end else begin
                r_out      <= w_masked;
                r_out_last <= 1'b1;
                r_state    <= ST_CFG_WAIT;
              end
            end
          end
          ST_EMIT_TAIL: begin
            if (w_len_zero) begin
              r_state <= ST_CFG_WAIT;
            end else if (w_slot_free) begin
              r_out      <= w_masked;
              r_out_last <= 1'b1;
              r_out_vld  <= 1'b1;
              r_state    <= ST_CFG_WAIT;
            end
          end
          ST_CFG_WAIT: begin
            if (w_slot_free && w_cfg_free) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_in_ready  = w_in_ready;
  assign data_out       = r_out;
  assign data_out_valid = r_out_vld;
  assign data_out_last  = r_out_last;
  assign cfg_size       = r_cfg_size;
  assign cfg_scheme     = SCHEME_ID;
  assign cfg_last       = 1'b1;
  assign cfg_valid      = r_cfg_vld;

`ifdef SHA256_MESSAGE_UNPAD_CHECK_EN
  // The pad bit lies in the tail, or in the held block when the message ends there;
  // the window is {hold, tail} with bit positions counted from its MSB.
  logic                          r_err;
  logic [SHA256_LEN_W+1:0]       w_need;
  logic                          w_pad_tail;
  logic [9:0]                    w_pos;
  logic [2*SHA256_BLOCK_W-1:0]   w_win;
  logic [2*SHA256_BLOCK_W-1:0]   w_zmask;
  logic                          w_pad_bit;
  logic                          w_bad;

  assign w_need     = ({2'b00, data_in[SHA256_LEN_W-1:0]} + 66'd576) >> 9;
  assign w_pad_tail = (({1'b0, data_in[63:9]} + 56'd1) == {1'b0, w_cnt_inc});
  assign w_pos      = {w_pad_tail, data_in[8:0]};
  assign w_win      = {(r_hold_vld ? r_hold : {SHA256_BLOCK_W{1'b0}}), data_in};
  assign w_zmask    = ({(2*SHA256_BLOCK_W){1'b1}} >> ({1'b0, w_pos} + 11'd1))
                      & {{(2*SHA256_BLOCK_W-SHA256_LEN_W){1'b1}}, {SHA256_LEN_W{1'b0}}};
  assign w_pad_bit  = w_win[~w_pos];
  assign w_bad      = (w_need != {11'd0, w_cnt_inc}) || !w_pad_bit || (|(w_win & w_zmask));

  always_ff @(posedge clk) begin
    if (sync_rst)                               r_err <= 1'b0;
    else if (w_accept && data_in_last && w_bad) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
